// File: rtl/frame_scan_pkg.sv
// Shared types and helpers for the frame raster scan controller.
// Optional stall support in frame_scan_ctrl is enabled with FRAME_SCAN_STALL_EN.
package frame_scan_pkg;

    // Scan sequencer states: idle, issuing reads, draining the write side.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    // Width of a counter able to hold the value n_states-1, at least one bit.
    // Called with N+LAT+1 so that the counter reaches N+LAT without wrapping.
    function automatic int beat_cnt_w(input int unsigned n_states);
        int w;
        w = $clog2(n_states);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Row-major raster address generator for one side (read or write) of the
// frame scan. The row/col registers are the address seen by the frame RAM;
// clr returns them to (0,0), inc advances one column with row carry.
module scan_addr_gen #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int ROWS  = 256,
    parameter int COLS  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;

    // Next address: clear has priority, otherwise step with column wrap and row carry.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                row_d = row_q;
                col_d = col_q + COL_ONE;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Address registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/frame_scan_ctrl.sv
// Read-then-write raster sequencer for a ROWS x COLS frame memory.
// A start issues N=ROWS*COLS read beats in row-major order on consecutive
// cycles; the same addresses are replayed as writes LAT cycles later.
// Compile with FRAME_SCAN_STALL_EN to add the stall port, which freezes the
// whole scan (including the read-to-write delay line) for one cycle per stall.
module frame_scan_ctrl
    import frame_scan_pkg::*;
#(
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int ROWS  = 256,
    parameter int COLS  = 256,
    parameter int LAT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef FRAME_SCAN_STALL_EN
    input  logic             stall,
`endif
    output logic             act,
    output logic             rd,
    output logic             wr,
    output logic [ROW_W-1:0] addr_row_r,
    output logic [COL_W-1:0] addr_col_r,
    output logic [ROW_W-1:0] addr_row_w,
    output logic [COL_W-1:0] addr_col_w,
    output logic             busy,
    output logic             done
);

    localparam int N     = ROWS * COLS;
    localparam int TOTAL = N + LAT;
    localparam int CNT_W = beat_cnt_w(TOTAL + 1);

    // The counter is 1 on the first read edge, so it equals TOTAL on the
    // last write edge; the edge after that finishes the scan.
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    scan_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LAT-1:0]   vsr_q;
    logic             wr_seen_q;
    logic             act_q;
    logic             rd_q;
    logic             wr_q;
    logic             busy_q;
    logic             done_q;

    logic             frz;
    logic             start_acc;
    logic             rd_more;
    logic             rd_d;
    logic             wr_d;
    logic             finish_d;
    logic             r_clr;
    logic             r_inc;
    logic             w_clr;
    logic             w_inc;
    logic             r_last;
    logic             w_last;

`ifdef FRAME_SCAN_STALL_EN
    assign frz = stall;
`else
    assign frz = 1'b0;
`endif

    // Decode this cycle's scan events. Beat 0 is issued on the start edge
    // itself; later beats follow while the read generator is not at the
    // final address. A write is due when a valid leaves the delay line.
    always_comb begin
        start_acc = (state_q == IDLE) && start && !frz;
        rd_more   = (state_q == READ) && !r_last && !frz;
        rd_d      = start_acc || rd_more;
        wr_d      = (state_q != IDLE) && vsr_q[LAT-1] && !frz;
        finish_d  = (state_q == DRAIN) && (cnt_q == CNT_END) && !frz;
        r_clr     = start_acc || abort;
        r_inc     = rd_more;
        w_clr     = start_acc || abort;
        // The first write shows the cleared (0,0) address, later ones step.
        w_inc     = wr_d && wr_seen_q && !w_last;
    end

    // Scan FSM with beat counter, read-to-write valid delay line and
    // registered strobes; abort acts like reset, stall freezes everything
    // except the strobes, which drop to zero for that cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vsr_q     <= '0;
            wr_seen_q <= 1'b0;
            act_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (frz) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            done_q    <= finish_d;
            wr_seen_q <= start_acc ? 1'b0 : (wr_seen_q | wr_d);
            vsr_q[0]  <= rd_d;
            for (int i = 1; i < LAT; i++) begin
                vsr_q[i] <= vsr_q[i-1];
            end
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        state_q <= READ;
                        cnt_q   <= CNT_ONE;
                        act_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        act_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (r_last) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q <= READ;
                    end
                end
                DRAIN: begin
                    if (finish_d) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        act_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DRAIN;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    act_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    scan_addr_gen #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) u_rd_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (r_clr),
        .inc  (r_inc),
        .row  (addr_row_r),
        .col  (addr_col_r),
        .last (r_last)
    );

    scan_addr_gen #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) u_wr_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .row  (addr_row_w),
        .col  (addr_col_w),
        .last (w_last)
    );

    assign act  = act_q;
    assign rd   = rd_q;
    assign wr   = wr_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
